// File: rtl/q_calc_pkg.sv
// -----------------------------------------------------------------------------
// q_calc_pkg
// Shared types and defaults for the Q_calculator round-robin arbiter.
//   arb_state_t     : arbiter FSM states
//   DEFAULT_WIDTH   : default operand/result width
//   DEFAULT_TIMEOUT : default WAIT-state cycle limit
// -----------------------------------------------------------------------------
package q_calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector: picks the first asserted request
// at or above i_ptr, wrapping from N-1 back to 0.
// Ports:
//   i_req     [N]         request vector
//   i_ptr     [clog2(N)]  highest-priority index this cycle
//   o_gnt     [N]         one-hot grant (all zero when no request)
//   o_gnt_idx [clog2(N)]  binary index of the grant
//   o_any                 at least one request is asserted
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_gnt_idx,
    output logic                 o_any
);

    localparam int IW = $clog2(N);
    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam int SW = IW + 1;

    logic [SW-1:0] w_pos;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_pos     = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, i_ptr} + SW'(k);
            if (w_pos >= SW'(N)) begin
                w_pos = w_pos - SW'(N);
            end
            if (!o_any && i_req[w_pos[IW-1:0]]) begin
                o_any                  = 1'b1;
                o_gnt[w_pos[IW-1:0]]   = 1'b1;
                o_gnt_idx              = w_pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/q_calc_arbiter.sv
// -----------------------------------------------------------------------------
// q_calc_arbiter
// Shares one external Q_calculator between NUM_REQ requesters. One transaction
// is in flight at a time: accept operands (IDLE), pulse the calculator
// (ISSUE), wait for its result or a timeout (WAIT), then hold the response
// until the granted requester takes it (RESP).
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_valid/o_req_ready per-requester request handshake
//   i_req_a..i_req_d        per-requester signed operands [NUM_REQ][WIDTH]
//   o_rsp_valid/i_rsp_ready per-requester response handshake (valid one-hot)
//   o_rsp_q, o_rsp_err      shared result; err marks a timeout (q = 0)
//   o_calc_valid_in, o_calc_a..o_calc_d   to calculator
//   i_calc_q, i_calc_valid_out            from calculator
// -----------------------------------------------------------------------------
module q_calc_arbiter
    import q_calc_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic        [NUM_REQ-1:0]              i_req_valid,
    output logic        [NUM_REQ-1:0]              o_req_ready,
    input  logic signed [NUM_REQ-1:0][WIDTH-1:0]   i_req_a,
    input  logic signed [NUM_REQ-1:0][WIDTH-1:0]   i_req_b,
    input  logic signed [NUM_REQ-1:0][WIDTH-1:0]   i_req_c,
    input  logic signed [NUM_REQ-1:0][WIDTH-1:0]   i_req_d,
    output logic        [NUM_REQ-1:0]              o_rsp_valid,
    input  logic        [NUM_REQ-1:0]              i_rsp_ready,
    output logic signed [WIDTH-1:0]                o_rsp_q,
    output logic                                   o_rsp_err,
    output logic                                   o_calc_valid_in,
    output logic signed [WIDTH-1:0]                o_calc_a,
    output logic signed [WIDTH-1:0]                o_calc_b,
    output logic signed [WIDTH-1:0]                o_calc_c,
    output logic signed [WIDTH-1:0]                o_calc_d,
    input  logic signed [WIDTH-1:0]                i_calc_q,
    input  logic                                   i_calc_valid_out
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t                r_state;
    logic        [IW-1:0]      r_ptr;
    logic        [IW-1:0]      r_gnt_idx;
    logic        [CW-1:0]      r_cnt;
    logic        [NUM_REQ-1:0] r_rsp_valid;
    logic signed [WIDTH-1:0]   r_rsp_q;
    logic                      r_rsp_err;
    logic                      r_calc_valid_in;
    logic signed [WIDTH-1:0]   r_calc_a;
    logic signed [WIDTH-1:0]   r_calc_b;
    logic signed [WIDTH-1:0]   r_calc_c;
    logic signed [WIDTH-1:0]   r_calc_d;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]      w_gnt_idx;
    logic               w_any;
    logic               w_req_hs;
    logic               w_rsp_hs;

    rr_picker #(
        .N (NUM_REQ)
    ) u_picker (
        .i_req     (i_req_valid),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    // Ready is offered only in IDLE and never while reset is asserted, so no
    // request can be consumed by a cycle that is about to be wiped.
    assign w_req_hs = (r_state == IDLE) && !i_rst && w_any;
    assign w_rsp_hs = (r_state == RESP) && i_rsp_ready[r_gnt_idx];

    always_comb begin
        o_req_ready = '0;
        if (w_req_hs) begin
            o_req_ready = w_gnt;
        end
    end

    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_q         = r_rsp_q;
    assign o_rsp_err       = r_rsp_err;
    assign o_calc_valid_in = r_calc_valid_in;
    assign o_calc_a        = r_calc_a;
    assign o_calc_b        = r_calc_b;
    assign o_calc_c        = r_calc_c;
    assign o_calc_d        = r_calc_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= IDLE;
            r_ptr           <= '0;
            r_gnt_idx       <= '0;
            r_cnt           <= '0;
            r_rsp_valid     <= '0;
            r_rsp_q         <= '0;
            r_rsp_err       <= 1'b0;
            r_calc_valid_in <= 1'b0;
            r_calc_a        <= '0;
            r_calc_b        <= '0;
            r_calc_c        <= '0;
            r_calc_d        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_hs) begin
                        r_gnt_idx       <= w_gnt_idx;
                        r_calc_a        <= i_req_a[w_gnt_idx];
                        r_calc_b        <= i_req_b[w_gnt_idx];
                        r_calc_c        <= i_req_c[w_gnt_idx];
                        r_calc_d        <= i_req_d[w_gnt_idx];
                        // Raised here so the pulse is visible during ISSUE.
                        r_calc_valid_in <= 1'b1;
                        r_state         <= ISSUE;
                    end
                end

                ISSUE: begin
                    r_calc_valid_in <= 1'b0;
                    r_cnt           <= '0;
                    r_state         <= WAIT;
                end

                WAIT: begin
                    // r_cnt holds the number of WAIT cycles already spent, so
                    // the TIMEOUT-th WAIT cycle is the last one. A result in
                    // that same cycle is tested first and therefore wins.
                    if (i_calc_valid_out) begin
                        r_rsp_q     <= i_calc_q;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= NUM_REQ'(1) << r_gnt_idx;
                        r_state     <= RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_q     <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= NUM_REQ'(1) << r_gnt_idx;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= '0;
                        r_ptr       <= (r_gnt_idx == IW'(NUM_REQ - 1)) ? '0
                                                                       : r_gnt_idx + IW'(1);
                        r_state     <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q_calc_arbiter.sv
`timescale 1ns/1ps
module tb_q_calc_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    logic        [N-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
    logic signed [N-1:0][W-1:0] req_a, req_b, req_c, req_d;
    logic signed [W-1:0]        rsp_q, calc_a, calc_b, calc_c, calc_d, calc_q;
    logic                       rsp_err, calc_vi, calc_vo;

    always #5 clk = ~clk;

    q_calc_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_a          (req_a),
        .i_req_b          (req_b),
        .i_req_c          (req_c),
        .i_req_d          (req_d),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_q          (rsp_q),
        .o_rsp_err        (rsp_err),
        .o_calc_valid_in  (calc_vi),
        .o_calc_a         (calc_a),
        .o_calc_b         (calc_b),
        .o_calc_c         (calc_c),
        .o_calc_d         (calc_d),
        .i_calc_q         (calc_q),
        .i_calc_valid_out (calc_vo)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    // Q = ((a-b)*(3c+1) - 4d) >>> 1, truncated to W bits.
    function automatic logic signed [W-1:0] qref(logic signed [W-1:0] a, logic signed [W-1:0] b,
                                                 logic signed [W-1:0] c, logic signed [W-1:0] d);
        longint t;
        t = ((longint'(a) - longint'(b)) * (3 * longint'(c) + 1) - 4 * longint'(d)) >>> 1;
        return W'(t);
    endfunction

    // First valid requester at or after p, wrapping.
    function automatic int rr_pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    typedef struct {
        int                  idx;
        logic signed [W-1:0] q;
        bit                  err;
        int                  due;
        logic signed [W-1:0] a, b, c, d;
    } exp_t;

    exp_t            sb[$];
    exp_t            e_new, e_head;
    int              model_ptr = 0;
    int              issue_cyc = -1;
    int              next_lat  = 3;
    int              issued_lat = 3;
    logic [N-1:0]    granted = '0;
    int              gnt_log[$];
    longint          last_q   [N];
    longint          last_err [N];
    int              g, eff;

    // ---------------- calculator stub ----------------
    // Answers issued_lat cycles after calc_valid_in; 0 means never answer.
    // calc_q carries noise whenever valid_out is low.
    int                  stub_cd = 0;
    bit                  stub_pend = 0;
    logic signed [W-1:0] stub_res;
    initial begin
        calc_vo = 1'b0;
        calc_q  = '0;
        forever begin
            @(posedge clk); #1;
            calc_vo = 1'b0;
            calc_q  = W'($urandom);
            if (stub_pend) begin
                stub_cd--;
                if (stub_cd == 0) begin
                    calc_vo   = 1'b1;
                    calc_q    = stub_res;
                    stub_pend = 0;
                end
            end
            if (calc_vi) begin
                stub_cd   = issued_lat;
                stub_pend = (issued_lat != 0);
                stub_res  = qref(calc_a, calc_b, calc_c, calc_d);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            model_ptr = 0;
            issue_cyc = -1;
        end else begin
            chk("calc_valid_in", calc_vi, (cyc == issue_cyc) ? 1 : 0);
            if (sb.size() == 0) begin
                g = rr_pick(req_valid, model_ptr);
                chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
                chk("rsp_valid_idle", rsp_valid, 0);
                if (g >= 0) begin
                    e_new.idx = g;
                    e_new.a = req_a[g]; e_new.b = req_b[g];
                    e_new.c = req_c[g]; e_new.d = req_d[g];
                    e_new.err = (next_lat == 0) || (next_lat > TO);
                    eff = e_new.err ? TO : next_lat;
                    e_new.q = e_new.err ? '0 : qref(e_new.a, e_new.b, e_new.c, e_new.d);
                    e_new.due = cyc + 2 + eff;
                    issue_cyc  = cyc + 1;
                    issued_lat = next_lat;
                    sb.push_back(e_new);
                    gnt_log.push_back(g);
                    granted[g] = 1'b1;
                end
            end else begin
                e_head = sb[0];
                chk("req_ready_busy", req_ready, 0);
                if (cyc < e_head.due) begin
                    chk("rsp_valid_early", rsp_valid, 0);
                    chk("calc_ops", {calc_a, calc_b, calc_c, calc_d},
                        {e_head.a, e_head.b, e_head.c, e_head.d});
                end else begin
                    chk("rsp_valid", rsp_valid, 1 << e_head.idx);
                    chk("rsp_q", rsp_q, e_head.q);
                    chk("rsp_err", rsp_err, e_head.err);
                    if (rsp_valid[e_head.idx] && rsp_ready[e_head.idx]) begin
                        last_q[e_head.idx]   = rsp_q;
                        last_err[e_head.idx] = rsp_err;
                        void'(sb.pop_front());
                        model_ptr = (e_head.idx + 1) % N;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (granted[i]) begin
                    req_valid[i] = 1'b0;
                    granted[i]   = 1'b0;
                end
            end
        end
    endtask

    task automatic raise(int i, int a, int b, int c, int d);
        req_a[i] = W'(a); req_b[i] = W'(b); req_c[i] = W'(c); req_d[i] = W'(d);
        req_valid[i] = 1'b1;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        rsp_ready = '1;
        while ((sb.size() != 0 || req_valid != '0 || granted != '0) && budget < 300) begin
            tick();
            budget++;
        end
        chk("drain_timeout", budget >= 300, 0);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_q"}, rsp_q, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_calc_vi"}, calc_vi, 0);
        chk({tag, "_calc_ops"}, {calc_a, calc_b, calc_c, calc_d}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid = '0; rsp_ready = '1;
        req_a = '0; req_b = '0; req_c = '0; req_d = '0;
        tick(3);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Single request from requester 0.
        next_lat = 3;
        raise(0, -74, -34, 20, 58);
        drain();
        chk("single_q", last_q[0], -1336);
        chk("single_err", last_err[0], 0);

        // All four requesters valid straight out of reset.
        rst = 1'b1;
        raise(0, 10, 3, 5, -7);
        raise(1, -20, 15, -4, 9);
        raise(2, 78, 29, 16, -67);
        raise(3, 5, 5, 30, 12);
        tick(2);
        rst = 1'b0;
        gnt_log.delete();
        next_lat = 2;
        drain();
        chk("order_len", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("order", gnt_log[i], i);
        chk("req2_q", last_q[2], 1334);

        // Pointer moves past the last served requester.
        next_lat = 1;
        raise(1, 7, 2, 1, 1);
        drain();
        gnt_log.delete();
        raise(0, 3, 1, 2, 0);
        raise(1, 4, 9, 1, 2);
        drain();
        chk("after1_first", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);
        raise(3, 1, 1, 1, 1);
        drain();
        gnt_log.delete();
        raise(0, 2, 2, 2, 2);
        raise(3, 6, 1, 0, 3);
        drain();
        chk("wrap_first", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);

        // Timeout, tie at the TIMEOUT boundary, and late stale results.
        next_lat = 0;
        raise(2, 11, 4, 3, 2);
        drain();
        chk("timeout_err", last_err[2], 1);
        chk("timeout_q", last_q[2], 0);
        next_lat = TO;
        raise(2, 11, 4, 3, 2);
        drain();
        chk("tie_err", last_err[2], 0);
        chk("tie_q", last_q[2], qref(11, 4, 3, 2));
        next_lat = TO + 2;
        raise(1, -9, 4, 6, 1);
        drain();
        chk("late_err", last_err[1], 1);
        tick(6);
        next_lat = TO + 1;
        raise(3, 9, 4, -6, 1);
        drain();
        chk("late9_err", last_err[3], 1);
        tick(6);

        // Response held off for several cycles while others wait.
        next_lat = 2;
        rsp_ready = '0;
        raise(3, 15, -3, 2, 5);
        tick(2);
        raise(0, 1, 2, 3, 4);
        raise(1, 5, 6, 7, 8);
        begin
            int b;
            b = 0;
            while (rsp_valid == '0 && b < 40) begin tick(); b++; end
            chk("hold_rsp_seen", b >= 40, 0);
        end
        tick(5);
        drain();

        // Reset in WAIT drops the transaction; pointer restarts at 0.
        next_lat = 1;
        raise(1, 2, 1, 1, 0);
        drain();
        next_lat = 6;
        raise(2, 30, 10, 2, 4);
        tick(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        tick(10);
        gnt_log.delete();
        next_lat = 2;
        raise(1, 8, 3, 1, 2);
        raise(3, 4, 4, 4, 4);
        drain();
        chk("post_reset_first", gnt_log.size() > 0 ? gnt_log[0] : -1, 1);

        // Randomized traffic.
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && !granted[i]) begin
                    if ($urandom_range(0, 99) < 30)
                        raise(i, int'($urandom_range(0, 120)) - 60, int'($urandom_range(0, 120)) - 60,
                              int'($urandom_range(0, 120)) - 60, int'($urandom_range(0, 120)) - 60);
                end else if (req_valid[i] && !granted[i] && $urandom_range(0, 99) < 4) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = N'($urandom_range(0, 15)) | N'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) next_lat = int'($urandom_range(0, TO + 2));
            else next_lat = int'($urandom_range(1, TO));
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
